// File: rtl/rom_arbiter.sv
// rom_arbiter: two-port ROM read arbiter with starvation guard and registered responses
module rom_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 64,
  parameter int MAX_WAIT = 4,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int WC_W = $clog2(MAX_WAIT + 1)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              rvalid0_o,
  output logic              rvalid1_o,
  input  logic              rready0_i,
  input  logic              rready1_i,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic              err0_o,
  output logic              err1_o,
  output logic              rom_ce_o,
  output logic [IDX_W-1:0]  rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i
);
  logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [WC_W-1:0]   wait_q, wait_d;
  logic              elig0, elig1, win1, bad;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] word;
  // Arbitration, address decode, ROM drive and next state of both response slots
  always_comb begin
    elig0 = req0_i & (!rvalid0_q | rready0_i);
    elig1 = req1_i & (!rvalid1_q | rready1_i);
    win1 = elig1 & (!elig0 | (wait_q == WC_W'(MAX_WAIT)));
    gnt1_o = rst_n_i & win1;
    gnt0_o = rst_n_i & elig0 & !win1;
    addr = gnt1_o ? addr1_i : addr0_i;
    bad = (addr[1:0] != 2'b00) | ((addr >> 2) >= ADDR_W'(DEPTH));
    rom_ce_o = (gnt0_o | gnt1_o) & !bad;
    rom_addr_o = rom_ce_o ? addr[IDX_W+1:2] : '0;
    word = bad ? '0 : rom_data_i;
    rvalid0_d = gnt0_o | (rvalid0_q & !rready0_i);
    err0_d = gnt0_o ? bad : err0_q;
    rdata0_d = gnt0_o ? word : rdata0_q;
    rvalid1_d = gnt1_o | (rvalid1_q & !rready1_i);
    err1_d = gnt1_o ? bad : err1_q;
    rdata1_d = gnt1_o ? word : rdata1_q;
    wait_d = (gnt1_o | !req1_i) ? '0 : (wait_q < WC_W'(MAX_WAIT)) ? wait_q + 1'b1 : wait_q;
  end
  // State registers; reset discards any pending response
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err0_q <= 1'b0;
      err1_q <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      wait_q <= '0;
    end else begin
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      err0_q <= err0_d;
      err1_q <= err1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      wait_q <= wait_d;
    end
  end
  assign rvalid0_o = rvalid0_q;
  assign rvalid1_o = rvalid1_q;
  assign err0_o = err0_q;
  assign err1_o = err1_q;
  assign rdata0_o = rdata0_q;
  assign rdata1_o = rdata1_q;
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: scenario tasks plus a response scoreboard for rom_arbiter
module tb_rom_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, rready0 = 1'b0, rready1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, rom_ce;
  logic [31:0] rdata0, rdata1, rom_data;
  logic [5:0]  rom_addr;
  logic [31:0] rom [64];
  logic [32:0] q0[$], q1[$];
  int tests = 0, fails = 0;

  rom_arbiter dut (
    .clk_i(clk), .rst_n_i(rst_n), .req0_i(req0), .req1_i(req1),
    .addr0_i(addr0), .addr1_i(addr1), .gnt0_o(gnt0), .gnt1_o(gnt1),
    .rvalid0_o(rvalid0), .rvalid1_o(rvalid1), .rready0_i(rready0), .rready1_i(rready1),
    .rdata0_o(rdata0), .rdata1_o(rdata1), .err0_o(err0), .err1_o(err1),
    .rom_ce_o(rom_ce), .rom_addr_o(rom_addr), .rom_data_i(rom_data)
  );

  always #5 clk = ~clk;
  assign rom_data = rom[rom_addr];

  function automatic logic [32:0] rsp_of(input logic [31:0] a);
    logic b;
    b = (a[1:0] != 2'b00) || ((a >> 2) >= 32'd64);
    return b ? {1'b1, 32'h0} : {1'b0, rom[a[7:2]]};
  endfunction

  // Scoreboard: pop on consumed responses, push on observed grants
  always @(negedge clk) if (rst_n) begin
    if (rvalid0 && rready0) begin
      tests++;
      if (q0.size() == 0) begin fails++; $display("FAIL sb0_unexpected got err=%b data=%h", err0, rdata0); end
      else begin
        logic [32:0] e;
        e = q0.pop_front();
        if ({err0, rdata0} !== e) begin fails++; $display("FAIL sb0 got %b/%h exp %b/%h", err0, rdata0, e[32], e[31:0]); end
      end
    end
    if (rvalid1 && rready1) begin
      tests++;
      if (q1.size() == 0) begin fails++; $display("FAIL sb1_unexpected got err=%b data=%h", err1, rdata1); end
      else begin
        logic [32:0] e;
        e = q1.pop_front();
        if ({err1, rdata1} !== e) begin fails++; $display("FAIL sb1 got %b/%h exp %b/%h", err1, rdata1, e[32], e[31:0]); end
      end
    end
    if (gnt0) q0.push_back(rsp_of(addr0));
    if (gnt1) q1.push_back(rsp_of(addr1));
  end

  always @(negedge rst_n) begin
    q0.delete();
    q1.delete();
  end

  task automatic test_reset();
    req0 = 1'b1; addr0 = 32'h8; req1 = 1'b1; addr1 = 32'h4;
    @(negedge clk);
    tests++; if ({gnt0, gnt1, rom_ce} !== 3'b000) begin fails++; $display("FAIL rst_gnt got %b exp 000", {gnt0, gnt1, rom_ce}); end
    tests++; if (rom_addr !== 6'd0) begin fails++; $display("FAIL rst_rom_addr got %0d exp 0", rom_addr); end
    tests++; if ({rvalid0, rvalid1, err0, err1} !== 4'b0) begin fails++; $display("FAIL rst_flags got %b exp 0000", {rvalid0, rvalid1, err0, err1}); end
    tests++; if ({rdata0, rdata1} !== 64'h0) begin fails++; $display("FAIL rst_rdata got %h/%h exp 0", rdata0, rdata1); end
    tests++; if (dut.wait_q !== 3'd0) begin fails++; $display("FAIL rst_wait got %0d exp 0", dut.wait_q); end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_read();
    @(posedge clk); #1;
    req0 = 1'b1; addr0 = 32'h8; rready0 = 1'b1;
    @(negedge clk);
    tests++; if ({gnt0, gnt1, rom_ce} !== 3'b101) begin fails++; $display("FAIL read_gnt got %b exp 101", {gnt0, gnt1, rom_ce}); end
    tests++; if (rom_addr !== 6'd2) begin fails++; $display("FAIL read_rom_addr got %0d exp 2", rom_addr); end
    @(posedge clk); #1;
    req0 = 1'b0;
    @(negedge clk);
    tests++; if ({rvalid0, err0, rdata0} !== {2'b10, 32'h00500093}) begin fails++; $display("FAIL read_rsp got %b/%b/%h exp 1/0/00500093", rvalid0, err0, rdata0); end
  endtask

  task automatic test_errors();
    @(posedge clk); #1;
    req0 = 1'b1; addr0 = 32'h6;
    @(negedge clk);
    tests++; if ({gnt0, rom_ce, rom_addr} !== {2'b10, 6'd0}) begin fails++; $display("FAIL mis_gnt got %b/%b/%0d exp 1/0/0", gnt0, rom_ce, rom_addr); end
    @(posedge clk); #1;
    addr0 = 32'h100;
    @(negedge clk);
    tests++; if ({gnt0, rom_ce} !== 2'b10) begin fails++; $display("FAIL oor_gnt got %b exp 10", {gnt0, rom_ce}); end
    tests++; if ({rvalid0, err0, rdata0} !== {2'b11, 32'h0}) begin fails++; $display("FAIL mis_rsp got %b/%b/%h exp 1/1/0", rvalid0, err0, rdata0); end
    @(posedge clk); #1;
    req0 = 1'b0;
    @(negedge clk);
    tests++; if ({rvalid0, err0, rdata0} !== {2'b11, 32'h0}) begin fails++; $display("FAIL oor_rsp got %b/%b/%h exp 1/1/0", rvalid0, err0, rdata0); end
  endtask

  task automatic test_contention();
    @(posedge clk); #1;
    req0 = 1'b1; req1 = 1'b1; addr0 = 32'h10; addr1 = 32'h20; rready0 = 1'b1; rready1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++; if ({gnt0, gnt1} !== ((i % 5 == 4) ? 2'b01 : 2'b10)) begin fails++; $display("FAIL cont_gnt[%0d] got %b exp %b", i, {gnt0, gnt1}, (i % 5 == 4) ? 2'b01 : 2'b10); end
      tests++; if (dut.wait_q !== 3'(i % 5)) begin fails++; $display("FAIL cont_wait[%0d] got %0d exp %0d", i, dut.wait_q, i % 5); end
    end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    req0 = 1'b1; addr0 = 32'h0C; rready0 = 1'b0;
    @(negedge clk);
    tests++; if (gnt0 !== 1'b1) begin fails++; $display("FAIL bp_first_gnt got %b exp 1", gnt0); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      tests++; if (gnt0 !== 1'b0) begin fails++; $display("FAIL bp_gnt[%0d] got %b exp 0", i, gnt0); end
      tests++; if ({rvalid0, rdata0} !== {1'b1, rom[3]}) begin fails++; $display("FAIL bp_hold[%0d] got %b/%h exp 1/%h", i, rvalid0, rdata0, rom[3]); end
    end
    @(posedge clk); #1;
    rready0 = 1'b1; addr0 = 32'h14;
    @(negedge clk);
    tests++; if ({gnt0, rdata0} !== {1'b1, rom[3]}) begin fails++; $display("FAIL bp_refill got %b/%h exp 1/%h", gnt0, rdata0, rom[3]); end
    @(posedge clk); #1;
    req0 = 1'b0;
    @(negedge clk);
    tests++; if ({rvalid0, rdata0} !== {1'b1, rom[5]}) begin fails++; $display("FAIL bp_next got %b/%h exp 1/%h", rvalid0, rdata0, rom[5]); end
  endtask

  task automatic test_slot_full();
    @(posedge clk); #1;
    req0 = 1'b1; addr0 = 32'h18; rready0 = 1'b0; rready1 = 1'b1;
    @(negedge clk);
    tests++; if (gnt0 !== 1'b1) begin fails++; $display("FAIL sf_fill got %b exp 1", gnt0); end
    @(posedge clk); #1;
    addr0 = 32'h1C; req1 = 1'b1; addr1 = 32'h28;
    @(negedge clk);
    tests++; if ({gnt0, gnt1, dut.wait_q} !== {2'b01, 3'd0}) begin fails++; $display("FAIL sf_gnt1 got %b/%b/%0d exp 0/1/0", gnt0, gnt1, dut.wait_q); end
    @(posedge clk); #1;
    addr1 = 32'h2C; rready1 = 1'b0;
    @(negedge clk);
    tests++; if ({gnt0, gnt1, dut.wait_q} !== {2'b00, 3'd0}) begin fails++; $display("FAIL sf_blocked got %b/%b/%0d exp 0/0/0", gnt0, gnt1, dut.wait_q); end
    tests++; if ({rvalid1, err1, rdata1} !== {2'b10, rom[10]}) begin fails++; $display("FAIL sf_rsp1 got %b/%b/%h exp 1/0/%h", rvalid1, err1, rdata1, rom[10]); end
    @(posedge clk); #1;
    @(negedge clk);
    tests++; if ({gnt1, dut.wait_q} !== {1'b0, 3'd1}) begin fails++; $display("FAIL sf_wait_inc got %b/%0d exp 0/1", gnt1, dut.wait_q); end
    @(posedge clk); #1;
    rready0 = 1'b1; rready1 = 1'b1;
    @(negedge clk);
    tests++; if ({gnt0, gnt1, dut.wait_q} !== {2'b10, 3'd2}) begin fails++; $display("FAIL sf_p0_wins got %b/%b/%0d exp 1/0/2", gnt0, gnt1, dut.wait_q); end
    @(posedge clk); #1;
    req0 = 1'b0;
    @(negedge clk);
    tests++; if ({gnt1, dut.wait_q} !== {1'b1, 3'd3}) begin fails++; $display("FAIL sf_p1_alone got %b/%0d exp 1/3", gnt1, dut.wait_q); end
    tests++; if ({rvalid0, rdata0} !== {1'b1, rom[7]}) begin fails++; $display("FAIL sf_rsp0 got %b/%h exp 1/%h", rvalid0, rdata0, rom[7]); end
    @(posedge clk); #1;
    req1 = 1'b0;
    @(negedge clk);
    tests++; if ({rvalid1, rdata1} !== {1'b1, rom[11]}) begin fails++; $display("FAIL sf_rsp1b got %b/%h exp 1/%h", rvalid1, rdata1, rom[11]); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    req1 = 1'b1; addr1 = 32'h08; rready1 = 1'b1;
    @(posedge clk); #1;
    addr1 = 32'h0C;
    @(negedge clk);
    tests++; if ({rvalid1, gnt1} !== 2'b11) begin fails++; $display("FAIL rm_setup got %b exp 11", {rvalid1, gnt1}); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if ({gnt0, gnt1, rom_ce, rvalid0, rvalid1, err0, err1} !== 7'b0) begin fails++; $display("FAIL rm_flags got %b exp 0", {gnt0, gnt1, rom_ce, rvalid0, rvalid1, err0, err1}); end
    tests++; if ({rom_addr, rdata0, rdata1} !== 70'h0) begin fails++; $display("FAIL rm_data got %0d/%h/%h exp 0", rom_addr, rdata0, rdata1); end
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if ({gnt1, rvalid1} !== 2'b10) begin fails++; $display("FAIL rm_first_gnt got %b exp 10", {gnt1, rvalid1}); end
    @(posedge clk); #1;
    req1 = 1'b0;
    @(negedge clk);
    tests++; if ({rvalid1, err1, rdata1} !== {2'b10, rom[3]}) begin fails++; $display("FAIL rm_rsp got %b/%b/%h exp 1/0/%h", rvalid1, err1, rdata1, rom[3]); end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = {8'hC0, 8'(i), 16'(i * 7 + 1)};
    rom[2] = 32'h00500093;
    test_reset();
    test_read();
    test_errors();
    test_contention();
    test_backpressure();
    test_slot_full();
    test_reset_mid();
    @(negedge clk);
    tests++; if (q0.size() + q1.size() != 0) begin fails++; $display("FAIL sb_drained got %0d/%0d pending exp 0/0", q0.size(), q1.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
